// File: rtl/io_writeback_unit.sv
// io_writeback_unit
// Merges ALU and load writebacks onto the single register-file write port.
// Address 0 is the I/O location. Writes to it never reach the SRAM. They
// update the LED register and are offered to a slow consumer as a stream.
//
// Build option:
//   WB_OUT_FIFO_EN  defined   -> the stream is buffered in a FIFO_DEPTH-entry queue
//                   undefined -> no storage; out_valid_o pulses for one cycle
//                                after each address-0 write, and out_data_o
//                                mirrors led_o
//
// Ports:
//   clk, rst                 clock (rising edge), asynchronous active-high reset
//   alu_valid_i/addr/data    ALU writeback; highest priority, always accepted
//   mem_valid_i/addr/data    load writeback; accepted when mem_ready_o is high
//   mem_ready_o              combinational accept for the load request
//   rf_we_o/wr_addr/wr_data  registered register-file write port
//   led_o                    last value written to address 0 (registered)
//   out_valid_o/out_ready_i  output stream handshake
//   out_data_o               output stream head
//   fifo_count_o             queue occupancy
//   overflow_o               sticky: an ALU address-0 write hit a full queue
module io_writeback_unit #(
  parameter int unsigned BUS_WIDTH  = 8,
  parameter int unsigned ADDR_WIDTH = 3,
  parameter int unsigned FIFO_DEPTH = 4
) (
  input  logic                        clk,
  input  logic                        rst,
  input  logic                        alu_valid_i,
  input  logic [ADDR_WIDTH-1:0]       alu_addr_i,
  input  logic [BUS_WIDTH-1:0]        alu_data_i,
  input  logic                        mem_valid_i,
  output logic                        mem_ready_o,
  input  logic [ADDR_WIDTH-1:0]       mem_addr_i,
  input  logic [BUS_WIDTH-1:0]        mem_data_i,
  output logic                        rf_we_o,
  output logic [ADDR_WIDTH-1:0]       rf_wr_addr_o,
  output logic [BUS_WIDTH-1:0]        rf_wr_data_o,
  output logic [BUS_WIDTH-1:0]        led_o,
  output logic                        out_valid_o,
  input  logic                        out_ready_i,
  output logic [BUS_WIDTH-1:0]        out_data_o,
  output logic [$clog2(FIFO_DEPTH):0] fifo_count_o,
  output logic                        overflow_o
);

  // Request accepted this cycle (ALU wins; the load needs mem_ready_o)
  logic                  acc_valid;
  logic [ADDR_WIDTH-1:0] acc_addr;
  logic [BUS_WIDTH-1:0]  acc_data;
  logic                  acc_zero;
  logic                  acc_rf;

  always_comb begin
    acc_valid = 1'b0;
    acc_addr  = '0;
    acc_data  = '0;
    if (alu_valid_i) begin
      acc_valid = 1'b1;
      acc_addr  = alu_addr_i;
      acc_data  = alu_data_i;
    end else if (mem_valid_i && mem_ready_o) begin
      acc_valid = 1'b1;
      acc_addr  = mem_addr_i;
      acc_data  = mem_data_i;
    end
  end

  assign acc_zero = acc_valid && (acc_addr == '0);
  assign acc_rf   = acc_valid && (acc_addr != '0);

  // Register-file write port and LED register
  logic                  rf_we_q,      rf_we_d;
  logic [ADDR_WIDTH-1:0] rf_wr_addr_q, rf_wr_addr_d;
  logic [BUS_WIDTH-1:0]  rf_wr_data_q, rf_wr_data_d;
  logic [BUS_WIDTH-1:0]  led_q,        led_d;

  always_comb begin
    rf_we_d      = acc_rf;
    rf_wr_addr_d = rf_wr_addr_q;
    rf_wr_data_d = rf_wr_data_q;
    led_d        = led_q;
    if (acc_rf) begin
      rf_wr_addr_d = acc_addr;
      rf_wr_data_d = acc_data;
    end
    if (acc_zero) begin
      led_d = acc_data;
    end
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      rf_we_q      <= 1'b0;
      rf_wr_addr_q <= '0;
      rf_wr_data_q <= '0;
      led_q        <= '0;
    end else begin
      rf_we_q      <= rf_we_d;
      rf_wr_addr_q <= rf_wr_addr_d;
      rf_wr_data_q <= rf_wr_data_d;
      led_q        <= led_d;
    end
  end

  assign rf_we_o      = rf_we_q;
  assign rf_wr_addr_o = rf_wr_addr_q;
  assign rf_wr_data_o = rf_wr_data_q;
  assign led_o        = led_q;

`ifdef WB_OUT_FIFO_EN
  localparam int unsigned CNT_W = $clog2(FIFO_DEPTH) + 1;
  localparam int unsigned PTR_W = $clog2(FIFO_DEPTH);

  logic [BUS_WIDTH-1:0] fifo_q [FIFO_DEPTH];
  logic [PTR_W-1:0]     wr_ptr_q, wr_ptr_d;
  logic [PTR_W-1:0]     rd_ptr_q, rd_ptr_d;
  logic [CNT_W-1:0]     count_q,  count_d;
  logic                 overflow_q, overflow_d;
  logic                 full;
  logic                 empty;
  logic                 push;
  logic                 pop;

  assign full  = (count_q == CNT_W'(FIFO_DEPTH));
  assign empty = (count_q == '0);

  // Fullness is the pre-edge state; a same-cycle pop does not open a slot
  assign mem_ready_o = ~alu_valid_i & ~((mem_addr_i == '0) & full);

  // Only an ALU write can reach address 0 while full; it is dropped
  assign push = acc_zero & ~full;
  assign pop  = ~empty & out_ready_i;

  // Queue pointers, occupancy and sticky overflow
  always_comb begin
    wr_ptr_d   = wr_ptr_q;
    rd_ptr_d   = rd_ptr_q;
    overflow_d = overflow_q;
    count_d    = count_q + CNT_W'(push) - CNT_W'(pop);
    if (push) begin
      wr_ptr_d = wr_ptr_q + PTR_W'(1);
    end
    if (pop) begin
      rd_ptr_d = rd_ptr_q + PTR_W'(1);
    end
    if (acc_zero && full) begin
      overflow_d = 1'b1;
    end
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      wr_ptr_q   <= '0;
      rd_ptr_q   <= '0;
      count_q    <= '0;
      overflow_q <= 1'b0;
    end else begin
      wr_ptr_q   <= wr_ptr_d;
      rd_ptr_q   <= rd_ptr_d;
      count_q    <= count_d;
      overflow_q <= overflow_d;
    end
  end

  // Entry storage; cleared on reset so the idle head reads as zero
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      fifo_q <= '{default: '0};
    end else if (push) begin
      fifo_q[wr_ptr_q] <= acc_data;
    end
  end

  assign out_valid_o  = ~empty;
  assign out_data_o   = fifo_q[rd_ptr_q];
  assign fifo_count_o = count_q;
  assign overflow_o   = overflow_q;
`else
  logic pulse_q;
  logic unused_out_ready;

  assign mem_ready_o = ~alu_valid_i;

  // One-cycle strobe following each accepted address-0 write
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      pulse_q <= 1'b0;
    end else begin
      pulse_q <= acc_zero;
    end
  end

  assign out_valid_o      = pulse_q;
  assign out_data_o       = led_q;
  assign fifo_count_o     = '0;
  assign overflow_o       = 1'b0;
  assign unused_out_ready = out_ready_i;
`endif

endmodule

// File: tb/tb_io_writeback_unit.sv
module tb_io_writeback_unit;

  localparam int unsigned BW    = 8;
  localparam int unsigned AW    = 3;
  localparam int unsigned DEPTH = 4;
  localparam int unsigned CW    = $clog2(DEPTH) + 1;

  logic          clk = 1'b0;
  logic          rst;
  logic          alu_valid;
  logic [AW-1:0] alu_addr;
  logic [BW-1:0] alu_data;
  logic          mem_valid;
  logic          mem_ready;
  logic [AW-1:0] mem_addr;
  logic [BW-1:0] mem_data;
  logic          rf_we;
  logic [AW-1:0] rf_wr_addr;
  logic [BW-1:0] rf_wr_data;
  logic [BW-1:0] led;
  logic          out_valid;
  logic          out_ready;
  logic [BW-1:0] out_data;
  logic [CW-1:0] fifo_count;
  logic          overflow;

  int total = 0;
  int bad   = 0;

  io_writeback_unit #(
    .BUS_WIDTH (BW),
    .ADDR_WIDTH(AW),
    .FIFO_DEPTH(DEPTH)
  ) dut (
    .clk         (clk),
    .rst         (rst),
    .alu_valid_i (alu_valid),
    .alu_addr_i  (alu_addr),
    .alu_data_i  (alu_data),
    .mem_valid_i (mem_valid),
    .mem_ready_o (mem_ready),
    .mem_addr_i  (mem_addr),
    .mem_data_i  (mem_data),
    .rf_we_o     (rf_we),
    .rf_wr_addr_o(rf_wr_addr),
    .rf_wr_data_o(rf_wr_data),
    .led_o       (led),
    .out_valid_o (out_valid),
    .out_ready_i (out_ready),
    .out_data_o  (out_data),
    .fifo_count_o(fifo_count),
    .overflow_o  (overflow)
  );

  always #5 clk = ~clk;

  // Reference model: architectural state plus a queue for the output stream
  logic          m_we;
  logic [AW-1:0] m_addr;
  logic [BW-1:0] m_data;
  logic [BW-1:0] m_led;
  logic          m_ovf;
  logic          m_pulse;
  logic [BW-1:0] m_q[$];

  task automatic model_reset();
    m_we = 1'b0; m_addr = '0; m_data = '0; m_led = '0;
    m_ovf = 1'b0; m_pulse = 1'b0;
    m_q.delete();
  endtask

  function automatic logic model_ready();
`ifdef WB_OUT_FIFO_EN
    return !alu_valid && !(mem_addr == '0 && m_q.size() == int'(DEPTH));
`else
    return !alu_valid;
`endif
  endfunction

  // Advance the model by one clock using the inputs present before the edge
  task automatic model_step();
    logic          acc;
    logic [AW-1:0] a;
    logic [BW-1:0] d;
`ifdef WB_OUT_FIFO_EN
    logic          full;
    full = (m_q.size() == int'(DEPTH));
`endif
    acc = 1'b0; a = '0; d = '0;
    if (alu_valid) begin
      acc = 1'b1; a = alu_addr; d = alu_data;
    end else if (mem_valid && model_ready()) begin
      acc = 1'b1; a = mem_addr; d = mem_data;
    end
    m_we = acc && (a != '0);
    if (m_we) begin
      m_addr = a; m_data = d;
    end
    m_pulse = acc && (a == '0);
    if (m_pulse) m_led = d;
`ifdef WB_OUT_FIFO_EN
    if (m_q.size() > 0 && out_ready) void'(m_q.pop_front());
    if (m_pulse) begin
      if (full) m_ovf = 1'b1;
      else m_q.push_back(d);
    end
`endif
  endtask

  task automatic drive_idle();
    alu_valid = 1'b0; alu_addr = '0; alu_data = '0;
    mem_valid = 1'b0; mem_addr = '0; mem_data = '0;
    out_ready = 1'b0;
  endtask

  task automatic do_reset();
    @(negedge clk);
    rst = 1'b1;
    drive_idle();
    @(negedge clk);
    rst = 1'b0;
    model_reset();
  endtask

  task automatic test_reset();
    do_reset();
    #1;
    total++; if (rf_we !== 1'b0) begin bad++; $display("FAIL rst_we got=%h want=0", rf_we); end
    total++; if (rf_wr_addr !== '0) begin bad++; $display("FAIL rst_addr got=%h want=0", rf_wr_addr); end
    total++; if (rf_wr_data !== '0) begin bad++; $display("FAIL rst_data got=%h want=0", rf_wr_data); end
    total++; if (led !== '0) begin bad++; $display("FAIL rst_led got=%h want=0", led); end
    total++; if (out_valid !== 1'b0) begin bad++; $display("FAIL rst_ovalid got=%h want=0", out_valid); end
    total++; if (fifo_count !== '0) begin bad++; $display("FAIL rst_count got=%h want=0", fifo_count); end
    total++; if (overflow !== 1'b0) begin bad++; $display("FAIL rst_ovf got=%h want=0", overflow); end
    total++; if (mem_ready !== 1'b1) begin bad++; $display("FAIL rst_mready got=%h want=1", mem_ready); end
  endtask

  task automatic test_arbitration();
    @(negedge clk);
    alu_valid = 1'b1; alu_addr = 3'd3; alu_data = 8'h5A;
    mem_valid = 1'b1; mem_addr = 3'd5; mem_data = 8'h11;
    #1;
    total++; if (mem_ready !== 1'b0) begin bad++; $display("FAIL arb_mready_blocked got=%h want=0", mem_ready); end
    @(posedge clk); #1;
    total++; if (rf_we !== 1'b1) begin bad++; $display("FAIL arb_alu_we got=%h want=1", rf_we); end
    total++; if (rf_wr_addr !== 3'd3) begin bad++; $display("FAIL arb_alu_addr got=%h want=3", rf_wr_addr); end
    total++; if (rf_wr_data !== 8'h5A) begin bad++; $display("FAIL arb_alu_data got=%h want=5a", rf_wr_data); end
    @(negedge clk);
    alu_valid = 1'b0;
    #1;
    total++; if (mem_ready !== 1'b1) begin bad++; $display("FAIL arb_mready_free got=%h want=1", mem_ready); end
    @(posedge clk); #1;
    total++; if (rf_we !== 1'b1) begin bad++; $display("FAIL arb_mem_we got=%h want=1", rf_we); end
    total++; if (rf_wr_addr !== 3'd5) begin bad++; $display("FAIL arb_mem_addr got=%h want=5", rf_wr_addr); end
    total++; if (rf_wr_data !== 8'h11) begin bad++; $display("FAIL arb_mem_data got=%h want=11", rf_wr_data); end
    @(negedge clk);
    drive_idle();
    @(posedge clk); #1;
    total++; if (rf_we !== 1'b0) begin bad++; $display("FAIL arb_idle_we got=%h want=0", rf_we); end
    total++; if (rf_wr_addr !== 3'd5) begin bad++; $display("FAIL arb_idle_addr_hold got=%h want=5", rf_wr_addr); end
    total++; if (rf_wr_data !== 8'h11) begin bad++; $display("FAIL arb_idle_data_hold got=%h want=11", rf_wr_data); end
  endtask

`ifdef WB_OUT_FIFO_EN
  task automatic test_fifo_fill();
    for (int i = 1; i <= 4; i++) begin
      @(negedge clk);
      alu_valid = 1'b1; alu_addr = '0; alu_data = BW'(i); out_ready = 1'b0;
      @(posedge clk); #1;
      total++; if (rf_we !== 1'b0) begin bad++; $display("FAIL fill_we_%0d got=%h want=0", i, rf_we); end
    end
    total++; if (led !== 8'h04) begin bad++; $display("FAIL fill_led got=%h want=04", led); end
    total++; if (fifo_count !== CW'(4)) begin bad++; $display("FAIL fill_count got=%0d want=4", fifo_count); end
    total++; if (out_data !== 8'h01) begin bad++; $display("FAIL fill_head got=%h want=01", out_data); end
    total++; if (rf_wr_addr !== 3'd5) begin bad++; $display("FAIL fill_addr_hold got=%h want=5", rf_wr_addr); end
    @(negedge clk);
    alu_data = 8'h05;
    @(posedge clk); #1;
    total++; if (led !== 8'h05) begin bad++; $display("FAIL ovf_led got=%h want=05", led); end
    total++; if (overflow !== 1'b1) begin bad++; $display("FAIL ovf_flag got=%h want=1", overflow); end
    total++; if (fifo_count !== CW'(4)) begin bad++; $display("FAIL ovf_count got=%0d want=4", fifo_count); end
    total++; if (out_data !== 8'h01) begin bad++; $display("FAIL ovf_head got=%h want=01", out_data); end
  endtask

  task automatic test_mem_block();
    logic [BW-1:0] exp_seq [4];
    exp_seq = '{8'h02, 8'h03, 8'h04, 8'h99};
    @(negedge clk);
    alu_valid = 1'b0; mem_valid = 1'b1; mem_addr = '0; mem_data = 8'h99; out_ready = 1'b1;
    #1;
    total++; if (mem_ready !== 1'b0) begin bad++; $display("FAIL blk_mready got=%h want=0", mem_ready); end
    total++; if (out_data !== 8'h01) begin bad++; $display("FAIL blk_pop_data got=%h want=01", out_data); end
    @(posedge clk); #1;
    total++; if (fifo_count !== CW'(3)) begin bad++; $display("FAIL blk_count got=%0d want=3", fifo_count); end
    total++; if (led !== 8'h05) begin bad++; $display("FAIL blk_led got=%h want=05", led); end
    @(negedge clk);
    out_ready = 1'b0;
    #1;
    total++; if (mem_ready !== 1'b1) begin bad++; $display("FAIL blk_mready_next got=%h want=1", mem_ready); end
    @(posedge clk); #1;
    total++; if (fifo_count !== CW'(4)) begin bad++; $display("FAIL blk_refill got=%0d want=4", fifo_count); end
    total++; if (led !== 8'h99) begin bad++; $display("FAIL blk_led2 got=%h want=99", led); end
    @(negedge clk);
    mem_valid = 1'b0; out_ready = 1'b1;
    for (int k = 0; k < 4; k++) begin
      #1;
      total++; if (out_data !== exp_seq[k]) begin bad++; $display("FAIL drain_%0d got=%h want=%h", k, out_data, exp_seq[k]); end
      @(negedge clk);
    end
    #1;
    total++; if (out_valid !== 1'b0) begin bad++; $display("FAIL drain_empty got=%h want=0", out_valid); end
    total++; if (overflow !== 1'b1) begin bad++; $display("FAIL ovf_sticky got=%h want=1", overflow); end
  endtask

  task automatic test_push_pop();
    @(negedge clk);
    out_ready = 1'b0; alu_valid = 1'b1; alu_addr = '0; alu_data = 8'hB1;
    @(negedge clk);
    alu_data = 8'hB2;
    @(negedge clk);
    alu_data = 8'hAA; out_ready = 1'b1;
    #1;
    total++; if (fifo_count !== CW'(2)) begin bad++; $display("FAIL pp_count_pre got=%0d want=2", fifo_count); end
    total++; if (out_data !== 8'hB1) begin bad++; $display("FAIL pp_head_pre got=%h want=b1", out_data); end
    @(posedge clk); #1;
    total++; if (fifo_count !== CW'(2)) begin bad++; $display("FAIL pp_count_post got=%0d want=2", fifo_count); end
    total++; if (out_data !== 8'hB2) begin bad++; $display("FAIL pp_head_post got=%h want=b2", out_data); end
    @(negedge clk);
    alu_valid = 1'b0;
    @(posedge clk); #1;
    total++; if (out_data !== 8'hAA) begin bad++; $display("FAIL pp_wrap_head got=%h want=aa", out_data); end
    total++; if (fifo_count !== CW'(1)) begin bad++; $display("FAIL pp_wrap_count got=%0d want=1", fifo_count); end
    @(posedge clk); #1;
    total++; if (out_valid !== 1'b0) begin bad++; $display("FAIL pp_empty got=%h want=0", out_valid); end
    @(negedge clk);
    drive_idle();
  endtask
`else
  task automatic test_addr0_pulse();
    @(negedge clk);
    alu_valid = 1'b1; alu_addr = '0; alu_data = 8'h7E; out_ready = 1'b0;
    @(posedge clk); #1;
    total++; if (rf_we !== 1'b0) begin bad++; $display("FAIL p0_we got=%h want=0", rf_we); end
    total++; if (rf_wr_addr !== 3'd5) begin bad++; $display("FAIL p0_addr_hold got=%h want=5", rf_wr_addr); end
    total++; if (led !== 8'h7E) begin bad++; $display("FAIL p0_led got=%h want=7e", led); end
    total++; if (out_valid !== 1'b1) begin bad++; $display("FAIL p0_pulse got=%h want=1", out_valid); end
    total++; if (out_data !== 8'h7E) begin bad++; $display("FAIL p0_data got=%h want=7e", out_data); end
    total++; if (fifo_count !== '0) begin bad++; $display("FAIL p0_count got=%0d want=0", fifo_count); end
    @(negedge clk);
    drive_idle();
    @(posedge clk); #1;
    total++; if (out_valid !== 1'b0) begin bad++; $display("FAIL p0_pulse_end got=%h want=0", out_valid); end
    @(negedge clk);
    mem_valid = 1'b1; mem_addr = '0; mem_data = 8'h33;
    #1;
    total++; if (mem_ready !== 1'b1) begin bad++; $display("FAIL p0_mready got=%h want=1", mem_ready); end
    @(posedge clk); #1;
    total++; if (led !== 8'h33) begin bad++; $display("FAIL p0_mem_led got=%h want=33", led); end
    total++; if (out_valid !== 1'b1) begin bad++; $display("FAIL p0_mem_pulse got=%h want=1", out_valid); end
    total++; if (overflow !== 1'b0) begin bad++; $display("FAIL p0_ovf got=%h want=0", overflow); end
    @(negedge clk);
    drive_idle();
  endtask
`endif

  task automatic test_back_to_back();
    for (int i = 0; i < 6; i++) begin
      @(negedge clk);
      alu_valid = (i % 2 == 1);
      alu_addr  = AW'(i + 1); alu_data = BW'(8'h20 + i);
      mem_valid = (i % 2 == 0);
      mem_addr  = AW'(i + 1); mem_data = BW'(8'h40 + i);
      @(posedge clk); #1;
      total++; if (rf_we !== 1'b1) begin bad++; $display("FAIL b2b_we_%0d got=%h want=1", i, rf_we); end
      total++; if (rf_wr_addr !== AW'(i + 1)) begin bad++; $display("FAIL b2b_addr_%0d got=%h want=%h", i, rf_wr_addr, AW'(i + 1)); end
      total++; if (rf_wr_data !== ((i % 2 == 1) ? BW'(8'h20 + i) : BW'(8'h40 + i))) begin
        bad++; $display("FAIL b2b_data_%0d got=%h", i, rf_wr_data);
      end
    end
    @(negedge clk);
    drive_idle();
  endtask

  task automatic test_reset_midstream();
`ifdef WB_OUT_FIFO_EN
    for (int i = 0; i < 3; i++) begin
      @(negedge clk);
      alu_valid = 1'b1; alu_addr = '0; alu_data = BW'(8'hC0 + i); out_ready = 1'b0;
    end
`else
    @(negedge clk);
    alu_valid = 1'b1; alu_addr = '0; alu_data = 8'hC0; out_ready = 1'b0;
`endif
    @(negedge clk);
    alu_valid = 1'b1; alu_addr = 3'd6; alu_data = 8'h66;
    @(posedge clk); #1;
    total++; if (rf_we !== 1'b1) begin bad++; $display("FAIL mid_pre_we got=%h want=1", rf_we); end
`ifdef WB_OUT_FIFO_EN
    total++; if (fifo_count !== CW'(3)) begin bad++; $display("FAIL mid_pre_count got=%0d want=3", fifo_count); end
`endif
    #1;
    rst = 1'b1;
    #1;
    total++; if (rf_we !== 1'b0) begin bad++; $display("FAIL mid_we got=%h want=0", rf_we); end
    total++; if (rf_wr_addr !== '0) begin bad++; $display("FAIL mid_addr got=%h want=0", rf_wr_addr); end
    total++; if (rf_wr_data !== '0) begin bad++; $display("FAIL mid_data got=%h want=0", rf_wr_data); end
    total++; if (led !== '0) begin bad++; $display("FAIL mid_led got=%h want=0", led); end
    total++; if (out_valid !== 1'b0) begin bad++; $display("FAIL mid_ovalid got=%h want=0", out_valid); end
    total++; if (out_data !== '0) begin bad++; $display("FAIL mid_odata got=%h want=0", out_data); end
    total++; if (fifo_count !== '0) begin bad++; $display("FAIL mid_count got=%0d want=0", fifo_count); end
    total++; if (overflow !== 1'b0) begin bad++; $display("FAIL mid_ovf got=%h want=0", overflow); end
    @(negedge clk);
    drive_idle();
    rst = 1'b0;
    model_reset();
  endtask

  task automatic test_random();
    logic          e_ov;
    logic          chk_od;
    logic [BW-1:0] e_od;
    logic [CW-1:0] e_cnt;
    do_reset();
    for (int n = 0; n < 800; n++) begin
      @(negedge clk);
      alu_valid = ($urandom_range(0, 3) == 0);
      alu_addr  = ($urandom_range(0, 2) == 0) ? '0 : AW'($urandom);
      alu_data  = BW'($urandom);
      mem_valid = ($urandom_range(0, 1) == 1);
      mem_addr  = ($urandom_range(0, 2) == 0) ? '0 : AW'($urandom);
      mem_data  = BW'($urandom);
      out_ready = ($urandom_range(0, 2) == 0);
      #1;
      total++; if (mem_ready !== model_ready()) begin bad++; $display("FAIL rnd_mready n=%0d got=%h want=%h", n, mem_ready, model_ready()); end
      model_step();
      @(posedge clk); #1;
`ifdef WB_OUT_FIFO_EN
      e_ov   = (m_q.size() > 0);
      chk_od = e_ov;
      e_od   = e_ov ? m_q[0] : '0;
      e_cnt  = CW'(m_q.size());
`else
      e_ov   = m_pulse;
      chk_od = 1'b1;
      e_od   = m_led;
      e_cnt  = '0;
`endif
      total++; if (rf_we !== m_we) begin bad++; $display("FAIL rnd_we n=%0d got=%h want=%h", n, rf_we, m_we); end
      total++; if (rf_wr_addr !== m_addr) begin bad++; $display("FAIL rnd_addr n=%0d got=%h want=%h", n, rf_wr_addr, m_addr); end
      total++; if (rf_wr_data !== m_data) begin bad++; $display("FAIL rnd_data n=%0d got=%h want=%h", n, rf_wr_data, m_data); end
      total++; if (led !== m_led) begin bad++; $display("FAIL rnd_led n=%0d got=%h want=%h", n, led, m_led); end
      total++; if (out_valid !== e_ov) begin bad++; $display("FAIL rnd_ovalid n=%0d got=%h want=%h", n, out_valid, e_ov); end
      total++; if (fifo_count !== e_cnt) begin bad++; $display("FAIL rnd_count n=%0d got=%0d want=%0d", n, fifo_count, e_cnt); end
      total++; if (overflow !== m_ovf) begin bad++; $display("FAIL rnd_ovf n=%0d got=%h want=%h", n, overflow, m_ovf); end
      if (chk_od) begin
        total++; if (out_data !== e_od) begin bad++; $display("FAIL rnd_odata n=%0d got=%h want=%h", n, out_data, e_od); end
      end
    end
    @(negedge clk);
    drive_idle();
  endtask

  initial begin
    rst = 1'b1;
    drive_idle();
    model_reset();
    test_reset();
    test_arbitration();
`ifdef WB_OUT_FIFO_EN
    test_fifo_fill();
    test_mem_block();
    test_push_pop();
`else
    test_addr0_pulse();
`endif
    test_back_to_back();
    test_reset_midstream();
    test_random();
    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
